// File: rtl/sys_host_cmd.sv
// sys_host_cmd: frames one host request into UART command bytes and returns the reply.
// Optional response timeout is built when HOST_CMD_TIMEOUT_EN is defined.
module sys_host_cmd #(
  parameter int Data_width     = 8,
  parameter int Address_width  = 4,
  parameter int Timeout_cycles = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [1:0]               Cmd_type,
  input  logic [Address_width-1:0] Cmd_addr,
  input  logic [Data_width-1:0]    Cmd_data,
  input  logic [Data_width-1:0]    Cmd_opB,
  input  logic [3:0]               Cmd_fun,
  input  logic                     Cmd_valid,
  output logic                     Cmd_ready,
  output logic [Data_width-1:0]    TX_p_data,
  output logic                     TX_d_valid,
  input  logic                     TX_busy,
  input  logic [Data_width-1:0]    RX_p_data,
  input  logic                     RX_d_valid,
  output logic [Data_width-1:0]    Rsp_data,
  output logic                     Rsp_valid,
  output logic                     Rsp_timeout
);

  localparam int DW = Data_width;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP
  } state_e;

  state_e                   state_q;
  logic [1:0]               idx_q;
  logic [1:0]               type_q;
  logic [Address_width-1:0] addr_q;
  logic [DW-1:0]            data_q;
  logic [DW-1:0]            opb_q;
  logic [3:0]               fun_q;
  logic                     ready_q;
  logic                     txv_q;
  logic [DW-1:0]            txd_q;
  logic [DW-1:0]            rsp_q;
  logic                     rspv_q;

  function automatic logic [DW-1:0] frame_byte(
    input logic [1:0]               t,
    input logic [1:0]               i,
    input logic [Address_width-1:0] a,
    input logic [DW-1:0]            d,
    input logic [DW-1:0]            b,
    input logic [3:0]               f
  );
    logic [DW-1:0] r;
    r = '0;
    case (t)
      2'b00: begin
        if (i == 2'd0)      r = DW'(8'hAA);
        else if (i == 2'd1) r = DW'(a);
        else                r = d;
      end
      2'b01: r = (i == 2'd0) ? DW'(8'hBB) : DW'(a);
      2'b10: begin
        if (i == 2'd0)      r = DW'(8'hCC);
        else if (i == 2'd1) r = d;
        else if (i == 2'd2) r = b;
        else                r = DW'(f);
      end
      default: r = (i == 2'd0) ? DW'(8'hDD) : DW'(f);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] t);
    logic [1:0] r;
    r = 2'd1;
    case (t)
      2'b00:   r = 2'd2;
      2'b10:   r = 2'd3;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int CW = $clog2(Timeout_cycles + 1);
  logic [CW-1:0] cnt_q;
  logic          to_q;
  assign Rsp_timeout = to_q;
`else
  assign Rsp_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
      ready_q <= 1'b1;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      rsp_q   <= '0;
      rspv_q  <= 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      rspv_q <= 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
      to_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (Cmd_valid) begin
            type_q  <= Cmd_type;
            addr_q  <= Cmd_addr;
            data_q  <= Cmd_data;
            opb_q   <= Cmd_opB;
            fun_q   <= Cmd_fun;
            idx_q   <= '0;
            txd_q   <= frame_byte(Cmd_type, 2'd0, Cmd_addr,
                                  Cmd_data, Cmd_opB, Cmd_fun);
            txv_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!TX_busy) begin
            if (idx_q == last_idx(type_q)) begin
              txv_q   <= 1'b0;
              state_q <= WAIT_RSP;
`ifdef HOST_CMD_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              idx_q <= idx_q + 2'd1;
              txd_q <= frame_byte(type_q, idx_q + 2'd1, addr_q,
                                  data_q, opb_q, fun_q);
            end
          end
        end
        WAIT_RSP: begin
          // A reply on the terminal count beats the timeout
          if (RX_d_valid) begin
            rsp_q   <= RX_p_data;
            rspv_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
`ifdef HOST_CMD_TIMEOUT_EN
          else if (cnt_q == CW'(Timeout_cycles - 1)) begin
            to_q    <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Cmd_ready  = ready_q;
  assign TX_d_valid = txv_q;
  assign TX_p_data  = txd_q;
  assign Rsp_data   = rsp_q;
  assign Rsp_valid  = rspv_q;

endmodule

// File: tb/tb_sys_host_cmd.sv
// tb_sys_host_cmd: table vectors, corner sequences and random requests
// checked against a frame-list reference model.
module tb_sys_host_cmd;

  logic       CLK;
  logic       RST;
  logic [1:0] Cmd_type;
  logic [3:0] Cmd_addr;
  logic [7:0] Cmd_data;
  logic [7:0] Cmd_opB;
  logic [3:0] Cmd_fun;
  logic       Cmd_valid;
  logic       Cmd_ready;
  logic [7:0] TX_p_data;
  logic       TX_d_valid;
  logic       TX_busy;
  logic [7:0] RX_p_data;
  logic       RX_d_valid;
  logic [7:0] Rsp_data;
  logic       Rsp_valid;
  logic       Rsp_timeout;

  sys_host_cmd #(
    .Data_width(8),
    .Address_width(4),
    .Timeout_cycles(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Cmd_type(Cmd_type),
    .Cmd_addr(Cmd_addr),
    .Cmd_data(Cmd_data),
    .Cmd_opB(Cmd_opB),
    .Cmd_fun(Cmd_fun),
    .Cmd_valid(Cmd_valid),
    .Cmd_ready(Cmd_ready),
    .TX_p_data(TX_p_data),
    .TX_d_valid(TX_d_valid),
    .TX_busy(TX_busy),
    .RX_p_data(RX_p_data),
    .RX_d_valid(RX_d_valid),
    .Rsp_data(Rsp_data),
    .Rsp_valid(Rsp_valid),
    .Rsp_timeout(Rsp_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         busy_n[4];
  bit         stray;
  bit         noise;
  int         wait_cyc;
  int         mode;
  logic [7:0] last_rsp;

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [7:0]  b;
    logic [3:0]  f;
    logic [7:0]  rsp;
    int          busy_idx;
    int          busy_cnt;
    bit          stray;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: the byte list each request type must put on the wire
  function automatic void model(input logic [1:0] t, input logic [3:0] a,
                                input logic [7:0] d, input logic [7:0] b,
                                input logic [3:0] f);
    exp_q.delete();
    case (t)
      2'b00: begin
        exp_q.push_back(8'hAA);
        exp_q.push_back({4'h0, a});
        exp_q.push_back(d);
      end
      2'b01: begin
        exp_q.push_back(8'hBB);
        exp_q.push_back({4'h0, a});
      end
      2'b10: begin
        exp_q.push_back(8'hCC);
        exp_q.push_back(d);
        exp_q.push_back(b);
        exp_q.push_back({4'h0, f});
      end
      default: begin
        exp_q.push_back(8'hDD);
        exp_q.push_back({4'h0, f});
      end
    endcase
  endfunction

  task automatic scramble();
    if (noise) begin
      Cmd_valid = 1'($urandom);
      Cmd_type  = 2'($urandom);
      Cmd_addr  = 4'($urandom);
      Cmd_data  = 8'($urandom);
      Cmd_opB   = 8'($urandom);
      Cmd_fun   = 4'($urandom);
    end
  endtask

  task automatic do_txn(input logic [1:0] t, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] b,
                        input logic [3:0] f, input logic [7:0] rsp);
    chk("ready_idle", Cmd_ready, 1);
    Cmd_type  = t;
    Cmd_addr  = a;
    Cmd_data  = d;
    Cmd_opB   = b;
    Cmd_fun   = f;
    Cmd_valid = 1'b1;
    step();
    Cmd_valid = 1'b0;
    chk("ready_low", Cmd_ready, 0);
    chk("rsp_pulse_end", Rsp_valid, 0);
    chk("rsp_hold", Rsp_data, last_rsp);
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int c = 0; c < busy_n[i]; c++) begin
        TX_busy = 1'b1;
        chk("tx_hold_v", TX_d_valid, 1);
        chk("tx_hold_d", TX_p_data, exp_q[i]);
        scramble();
        step();
      end
      TX_busy = 1'b0;
      if (stray && i == 0) begin
        RX_d_valid = 1'b1;
        RX_p_data  = 8'($urandom);
      end
      chk("tx_v", TX_d_valid, 1);
      chk("tx_d", TX_p_data, exp_q[i]);
      scramble();
      step();
      RX_d_valid = 1'b0;
    end
    Cmd_valid = 1'b0;
    chk("tx_done", TX_d_valid, 0);
    chk("ready_wait", Cmd_ready, 0);
`ifdef HOST_CMD_TIMEOUT_EN
    if (mode == 1) begin
      for (int k = 1; k < 16; k++) begin
        step();
        chk("to_early", Rsp_timeout, 0);
      end
      step();
      chk("to_fire", Rsp_timeout, 1);
      chk("to_ready", Cmd_ready, 1);
      chk("to_norsp", Rsp_valid, 0);
      chk("to_data", Rsp_data, last_rsp);
      return;
    end
    if (mode == 2) wait_cyc = 15;
`else
    if (mode == 1) begin
      for (int k = 0; k < 40; k++) step();
      chk("noto", Rsp_timeout, 0);
      chk("noto_ready", Cmd_ready, 0);
      wait_cyc = 0;
    end
    if (mode == 2) wait_cyc = 15;
`endif
    for (int k = 0; k < wait_cyc; k++) begin
      step();
      chk("no_early_rsp", Rsp_valid, 0);
    end
    RX_d_valid = 1'b1;
    RX_p_data  = rsp;
    step();
    RX_d_valid = 1'b0;
    chk("rsp_valid", Rsp_valid, 1);
    chk("rsp_data", Rsp_data, rsp);
    chk("rsp_ready", Cmd_ready, 1);
    chk("rsp_no_to", Rsp_timeout, 0);
    last_rsp = rsp;
  endtask

  task automatic clear_opts();
    for (int i = 0; i < 4; i++) busy_n[i] = 0;
    stray    = 1'b0;
    noise    = 1'b0;
    wait_cyc = 2;
    mode     = 0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 4'h5, 8'h33, 8'h00, 4'h0, 8'h33, -1, 0, 1'b0,
               2, 32'hAA053300};
    tbl[0].n = 3;
    tbl[1] = '{2'b01, 4'h7, 8'h00, 8'h00, 4'h0, 8'h55, 1, 3, 1'b0,
               2, 32'hBB070000};
    tbl[2] = '{2'b10, 4'h0, 8'h12, 8'h34, 4'h0, 8'h46, -1, 0, 1'b0,
               4, 32'hCC123400};
    tbl[3] = '{2'b11, 4'h0, 8'h00, 8'h00, 4'h5, 8'h76, -1, 0, 1'b1,
               2, 32'hDD050000};

    RST        = 1'b1;
    Cmd_type   = '0;
    Cmd_addr   = '0;
    Cmd_data   = '0;
    Cmd_opB    = '0;
    Cmd_fun    = '0;
    Cmd_valid  = 1'b0;
    TX_busy    = 1'b0;
    RX_p_data  = '0;
    RX_d_valid = 1'b0;
    last_rsp   = 8'h00;
    #2 RST = 1'b0;
    #2;
    chk("rst_ready", Cmd_ready, 1);
    chk("rst_txv", TX_d_valid, 0);
    chk("rst_txd", TX_p_data, 0);
    chk("rst_rspv", Rsp_valid, 0);
    chk("rst_to", Rsp_timeout, 0);
    chk("rst_rspd", Rsp_data, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    step();

    foreach (tbl[v]) begin
      clear_opts();
      exp_q.delete();
      for (int i = 0; i < tbl[v].n; i++)
        exp_q.push_back(tbl[v].exp[31-8*i -: 8]);
      if (tbl[v].busy_idx >= 0) busy_n[tbl[v].busy_idx] = tbl[v].busy_cnt;
      stray = tbl[v].stray;
      do_txn(tbl[v].t, tbl[v].a, tbl[v].d, tbl[v].b, tbl[v].f, tbl[v].rsp);
    end

    clear_opts();
    mode = 1;
    model(2'b01, 4'h3, 8'h00, 8'h00, 4'h0);
    do_txn(2'b01, 4'h3, 8'h00, 8'h00, 4'h0, 8'h9A);
    clear_opts();
    mode = 2;
    model(2'b11, 4'h0, 8'h00, 8'h00, 4'h9);
    do_txn(2'b11, 4'h0, 8'h00, 8'h00, 4'h9, 8'hC3);

    // Reset in the middle of a type-10 frame
    clear_opts();
    model(2'b10, 4'h0, 8'hA1, 8'hB2, 4'h7);
    Cmd_type  = 2'b10;
    Cmd_data  = 8'hA1;
    Cmd_opB   = 8'hB2;
    Cmd_fun   = 4'h7;
    Cmd_valid = 1'b1;
    step();
    Cmd_valid = 1'b0;
    chk("mid_b0", TX_p_data, 8'hCC);
    step();
    chk("mid_b1", TX_p_data, 8'hA1);
    step();
    chk("mid_b2", TX_p_data, 8'hB2);
    RST = 1'b0;
    #1;
    chk("mid_rst_txv", TX_d_valid, 0);
    chk("mid_rst_ready", Cmd_ready, 1);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    step();
    last_rsp = 8'h00;
    do_txn(2'b10, 4'h0, 8'hA1, 8'hB2, 4'h7, 8'h5E);

    for (int r = 0; r < 40; r++) begin
      logic [1:0] t;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] b;
      logic [3:0] f;
      clear_opts();
      t = 2'($urandom);
      a = 4'($urandom);
      d = 8'($urandom);
      b = 8'($urandom);
      f = 4'($urandom);
      for (int i = 0; i < 4; i++) busy_n[i] = $urandom_range(0, 2);
      stray    = 1'($urandom);
      noise    = 1'($urandom);
      wait_cyc = $urandom_range(0, 5);
      model(t, a, d, b, f);
      do_txn(t, a, d, b, f, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_host_cmd.md
# sys_host_cmd

Host-side command initiator for the UART register-file/ALU command protocol. It accepts one parallel request, serialises it into the framed byte sequence the system controller decodes (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands), and pushes those bytes to the UART transmitter. It then waits for the single response byte from the UART receiver and returns it to the requester. The block sits in host or bench infrastructure, on the opposite side of the UART link from the system controller.

## Interface
- Data_width, 8, byte width of frame bytes and response
- Address_width, 4, register-file address width; zero-extended to Data_width on the wire
- Timeout_cycles, 50000, WAIT_RSP cycles before a timeout is declared
- CLK  in  1  clock
- RST  in  1  asynchronous, active-low reset
- Cmd_type  in  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands
- Cmd_addr  in  Address_width  RF address (types 00, 01)
- Cmd_data  in  Data_width  RF write data (00) or operand A (10)
- Cmd_opB  in  Data_width  operand B (10)
- Cmd_fun  in  4  ALU function (10, 11); zero-extended on the wire
- Cmd_valid  in  1  request strobe
- Cmd_ready  out  1  block idle, request accepted when Cmd_valid & Cmd_ready
- TX_p_data  out  Data_width  byte to UART TX
- TX_d_valid  out  1  byte valid, held until accepted
- TX_busy  in  1  UART TX cannot accept
- RX_p_data  in  Data_width  byte from UART RX
- RX_d_valid  in  1  one-cycle receive strobe
- Rsp_data  out  Data_width  response byte
- Rsp_valid  out  1  one-cycle response strobe
- Rsp_timeout  out  1  one-cycle timeout strobe

## Operation
- States: IDLE, SEND, WAIT_RSP.
- IDLE: Cmd_ready=1. On Cmd_valid, latch all Cmd_* fields, clear byte index, go SEND. Inputs are not sampled again until the next IDLE.
- Frames, with byte 0 first:
  - 00: AA, addr, data. Three bytes.
  - 01: BB, addr. Two bytes.
  - 10: CC, A, B, fun. Four bytes.
  - 11: DD, fun. Two bytes.
- SEND: TX_d_valid=1 and TX_p_data=frame[index].
  - A byte is accepted at a posedge where TX_d_valid & !TX_busy.
  - On acceptance, index increments. On the last byte, go WAIT_RSP.
  - TX_p_data must not change while a byte is unaccepted.
- WAIT_RSP: exactly one response byte per frame, for every type, including a write.
  - On RX_d_valid, latch RX_p_data, pulse Rsp_valid, go IDLE.
- RX_d_valid in IDLE or SEND is ignored.
- Cmd_valid while Cmd_ready=0 is ignored; there is no queuing.
- Timeout (when compiled in): a counter runs only in WAIT_RSP and clears on entry.
  - When the count reaches Timeout_cycles-1 with no RX_d_valid, pulse Rsp_timeout and go IDLE.
  - If RX_d_valid coincides with the terminal count, the response wins and there is no timeout.
- Reset mid-operation aborts immediately to IDLE. A partially sent frame is abandoned with no recovery byte.

## Timing
- Reset values: Cmd_ready=1; TX_d_valid=0; TX_p_data=0; Rsp_valid=0; Rsp_timeout=0; Rsp_data=0; state IDLE; counters 0.
- All outputs are registered.
- Byte 0 is presented in the cycle after the accepting edge.
- With TX_busy=0, bytes go back-to-back, one per cycle, and TX_d_valid stays high across the frame.
- The cycle after the last byte is accepted: TX_d_valid=0.
- The cycle after the RX_d_valid edge: Rsp_valid=1, Rsp_data valid, and Cmd_ready=1 in the same cycle.
- Rsp_data holds until the next response.
- Minimum turnaround: a new Cmd_valid can be accepted in the same cycle Rsp_valid is high.
- Timeout fires Timeout_cycles cycles after entering WAIT_RSP. Rsp_timeout and Cmd_ready rise together.

## Configuration
- HOST_CMD_TIMEOUT_EN defined: the timeout counter and Rsp_timeout behave as above.
- Not defined: no counter is built, Rsp_timeout is tied to 0, and WAIT_RSP waits indefinitely; only reset or a response exits it.

## Test plan
- Type 00, addr 5, data 0x33, TX_busy=0:
  - TX bytes AA, 05, 33 on three consecutive cycles.
  - RX 0x33 → Rsp_valid one cycle later with Rsp_data=0x33, Cmd_ready=1.
- Type 01, addr 7, with TX_busy high for 3 cycles on byte 1:
  - 0x07 is held stable for those cycles, then accepted.
  - RX 0x55 → Rsp_data=0x55.
- Type 10, A=0x12, B=0x34, fun=0:
  - TX CC, 12, 34, 00.
  - RX 0x46 → Rsp_data=0x46.
- Type 11, fun=5:
  - TX DD, 05.
  - A stray RX_d_valid during SEND is ignored.
  - RX 0x76 → exactly one Rsp_valid.
- Timeout with macro defined and Timeout_cycles=16, no RX:
  - Rsp_timeout pulses 16 cycles after WAIT_RSP entry.
  - Repeat with RX_d_valid on the terminal cycle → Rsp_valid=1, Rsp_timeout=0.
- RST low after byte 1 of a type-10 frame:
  - TX_d_valid=0 and Cmd_ready=1 immediately.
  - The next request sends a complete fresh frame.
